bus_mux_arb: RTL
================

# bus_mux_arb

Parametrised N-channel, W-bit registered bus multiplexer with round-robin or fixed-select arbitration and a valid/ready output handshake; the successor to the two-input 4-bit address mux in the SAP-1 datapath. It sits between multiple bus sources (PC, IR operand, RAM, ALU) and a single consumer such as the MAR or W-bus register. It replaces the combinational select with a one-cycle registered path that holds the output until the consumer accepts it.

## Interface
- WIDTH, 4: data width of every channel and of the output.
- CHANNELS, 4: number of input channels, ≥2.
- SEL_W, $clog2(CHANNELS): width of select/index signals (derived, not overridden).
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, synchronous, active-low.
- mode  input  1  0 = fixed select (channel `sel_in`), 1 = round-robin.
- sel_in  input  SEL_W  channel index used in fixed mode.
- req  input  CHANNELS  per-channel request; bit i qualifies `data_in` slice i.
- data_in  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- ack  output  CHANNELS  one-hot, combinational; high in the capture cycle for the granted channel.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  SEL_W  index of the channel that supplied `out_data`.
- out_valid  output  1  `out_data`/`out_sel` hold an unaccepted word.
- out_ready  input  1  consumer accepts when `out_valid && out_ready`.
- sel_err  output  1  registered one-cycle pulse: fixed mode with `sel_in ≥ CHANNELS` while any req is high.

## Operation
- Two states, EMPTY (`out_valid=0`) and FULL (`out_valid=1`).
- Capture condition: `(!out_valid || out_ready) && winner_exists`. On capture: `out_data` ← winner data, `out_sel` ← winner index, `out_valid` ← 1, `ack[winner]`=1 in the same cycle.
- FULL with `out_ready=1` and no winner → EMPTY. FULL with `out_ready=0` → outputs frozen and `ack`=0.
- Fixed mode: winner = `sel_in` only if `sel_in < CHANNELS` and `req[sel_in]`; other requests are ignored. The RR pointer does not move.
- Round-robin mode: search starts at `(last+1) mod CHANNELS` and wraps. The first set req wins. `last` ← winner on capture only.
- Requesters hold `req` and data until they see `ack`. Dropping `req` before `ack` withdraws the request without error.
- `mode`/`sel_in` are sampled every cycle. A change while FULL affects only the next capture, never the held word.
- Out-of-range `sel_in` in fixed mode: no capture; `sel_err` pulses each cycle the condition holds with any req high.

## Timing
- Reset (`rst_n=0` at a clk edge): `out_valid`=0, `out_data`=0, `out_sel`=0, `sel_err`=0, `last`=CHANNELS-1 so channel 0 has first priority. `ack` is 0 while `rst_n`=0.
- Reset mid-FULL discards the held word; a requester acked in that cycle is not re-served.
- Latency is 1 cycle: capture at edge k gives `out_valid` from edge k onward, with `ack` high during cycle k-1→k.
- Throughput: one word per cycle while `out_ready` stays high. Accept and new capture occur in the same edge (back-to-back, no bubble).
- Simultaneous accept with no request: `out_valid` falls at that edge.
- `ack` is purely combinational from `req`, `mode`, `sel_in`, `last`, `out_valid`, `out_ready`, and has no path from `out_data`.

## Structure
- Shared package `bus_mux_pkg`: `MODE_FIXED`=1'b0, `MODE_RR`=1'b1, and the `sel_t` width helper.
- Sub-module `rr_arbiter` (CHANNELS param): inputs `req` and `last`, outputs one-hot `grant`, `grant_idx` and `any`. It is reused for the fixed-mode path by masking `req` to a single bit.
- The top level holds the output register, FSM, `last` pointer, and `sel_err` flop.

## Test plan
- Reset then idle: `rst_n`=0 for 2 cycles → `out_valid`=0, `out_data`=0, `ack`=0, `sel_err`=0.
- Round-robin fairness: mode=1, `req`=4'b1111, `out_ready`=1 for 8 cycles → `out_sel` sequence 0,1,2,3,0,1,2,3; data slices 4'h1..4'h4 appear in order.
- Backpressure: RR, `req`=4'b0110, `out_ready`=0 for 3 cycles after first capture → `out_sel`=1 held, `ack`=0. Then `out_ready`=1 → next capture is channel 2.
- Fixed select: mode=0, `sel_in`=2, `req`=4'b1011 → no capture. Then `req[2]`=1 with data 4'hA → `ack`=4'b0100, next cycle `out_data`=4'hA, `out_sel`=2.
- Out-of-range: CHANNELS=3, mode=0, `sel_in`=3, `req`=3'b111 → `sel_err` pulses, `out_valid` stays 0.
- Reset mid-FULL: capture channel 1, hold `out_ready`=0, assert `rst_n`=0 for one edge → `out_valid`=0. Next RR grant goes to channel 0.

Source files
------------

// File: rtl/bus_mux_pkg.sv
// Shared definitions for the registered bus multiplexer/arbiter slice.
// Mode encodings and the select-width helper used by every module that sizes an index.
package bus_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Width of a channel index; never below one bit so two-channel builds stay legal.
  function automatic int sel_width(input int channels);
    return (channels > 2) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/bus_mux_arb_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last+1 (wrapping) for the first request.
// Fixed-select callers mask req down to one bit, so the search start no longer matters.
module rr_arbiter
  import bus_mux_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    last,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx,
  output logic                any
);

  always_comb begin : search
    int               pos;
    logic [SEL_W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    pos       = 0;
    idx       = '0;
    // Offsets 1..CHANNELS visit every channel once; offset CHANNELS is `last` itself.
    for (int off = 1; off <= CHANNELS; off++) begin
      pos = (int'(last) + off) % CHANNELS;
      idx = SEL_W'(pos);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/bus_mux_arb.sv
// N-channel registered bus multiplexer with fixed-select or round-robin arbitration
// and a valid/ready output register that holds each word until the consumer takes it.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_EMPTY | output register holds no word; out_valid low
//   ST_FULL  | out_data/out_sel hold an unaccepted word; out_valid high
module bus_mux_arb
  import bus_mux_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic [CHANNELS-1:0]       req,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [CHANNELS-1:0]       ack,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sel_err
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic [SEL_W:0] CH_LIMIT = (SEL_W + 1)'(CHANNELS);

  logic [0:0]          state_q;
  logic [SEL_W-1:0]    last_q;
  logic [WIDTH-1:0]    data_q;
  logic [SEL_W-1:0]    sel_q;
  logic                sel_err_q;

  logic                sel_ok;
  logic [CHANNELS-1:0] req_fixed;
  logic [CHANNELS-1:0] req_arb;
  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    grant_idx;
  logic                any;
  logic                can_load;
  logic                capture;
  logic                accept;
  logic [WIDTH-1:0]    win_data;

  assign sel_ok = {1'b0, sel_in} < CH_LIMIT;

  always_comb begin
    req_fixed = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel_ok && (sel_in == SEL_W'(i))) begin
        req_fixed[i] = req[i];
      end
    end
  end

  assign req_arb = (mode == MODE_RR) ? req : req_fixed;

  rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arb (
    .req       (req_arb),
    .last      (last_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) begin
        win_data = data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign can_load  = !out_valid || out_ready;
  assign capture   = rst_n && can_load && any;
  assign accept    = out_valid && out_ready;
  // ack is the capture strobe steered to the winner; it never looks at the held word.
  assign ack       = capture ? grant : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      last_q    <= SEL_W'(CHANNELS - 1);
      data_q    <= '0;
      sel_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= (mode == MODE_FIXED) && !sel_ok && (|req);
      if (capture) begin
        state_q <= ST_FULL;
        data_q  <= win_data;
        sel_q   <= grant_idx;
        if (mode == MODE_RR) begin
          last_q <= grant_idx;
        end
      end else if (accept) begin
        state_q <= ST_EMPTY;
      end
    end
  end

  assign out_data = data_q;
  assign out_sel  = sel_q;
  assign sel_err  = sel_err_q;

endmodule
